// File: rtl/rx_sync_div_if.sv
// Signal bundle between the receive-path frame marker source and the
// frame synchroniser / rate divider.
interface rx_sync_div_if;
  logic       sync_in;
  logic       en_2;
  logic       en_16;
  logic       en_32;
  logic [4:0] phase;
  logic       locked;
  logic       sync_err;

  // Side that supplies frame markers and consumes strobes and status.
  modport master (
    output sync_in,
    input  en_2, en_16, en_32, phase, locked, sync_err
  );

  // Side that is the synchroniser itself.
  modport slave (
    input  sync_in,
    output en_2, en_16, en_32, phase, locked, sync_err
  );
endinterface

// File: rtl/rx_sync_div.sv
// Frame synchroniser and rate divider. Hunts for a periodic 1-cycle frame
// marker, confirms it over several frames, then free-runs a 32-cycle phase
// counter that produces clk/2, clk/16 and clk/32 strobes while locked.
// Faults in lock are counted; enough of them drop back to hunting.
module rx_sync_div #(
  parameter int CONFIRM_N = 2,
  parameter int LOSS_N    = 3
) (
  input logic         clk,
  input logic         rst,
  rx_sync_div_if.slave bus
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [2:0] CONFIRM_MAX = 3'(CONFIRM_N);
  localparam logic [2:0] LOSS_MAX    = 3'(LOSS_N);

  state_t     state, state_nx;
  logic [4:0] phase_q, phase_nx;
  logic [2:0] confirm_q, confirm_nx;
  logic [2:0] fault_q, fault_nx;
  logic       err_q, err_nx;
  logic       on_phase, miss, is_locked;

  assign on_phase  = bus.sync_in && (phase_q == 5'd0);
  assign miss      = !bus.sync_in && (phase_q == 5'd0);
  assign is_locked = (state == LOCKED);

  // Next-state logic: hunt, confirm alignment, then track with fault budget.
  always_comb begin
    state_nx   = state;
    phase_nx   = phase_q;
    confirm_nx = confirm_q;
    fault_nx   = fault_q;
    err_nx     = 1'b0;
    case (state)
      SEARCH: begin
        phase_nx = 5'd0;
        if (bus.sync_in) begin
          phase_nx   = 5'd1;
          confirm_nx = 3'd0;
          state_nx   = VERIFY;
        end
      end
      VERIFY: begin
        phase_nx = phase_q + 5'd1;
        if (on_phase) begin
          confirm_nx = confirm_q + 3'd1;
          if (confirm_q + 3'd1 == CONFIRM_MAX) begin
            state_nx = LOCKED;
            fault_nx = 3'd0;
          end
        end else if (bus.sync_in) begin
          phase_nx   = 5'd1;
          confirm_nx = 3'd0;
        end else if (miss) begin
          state_nx = SEARCH;
          phase_nx = 5'd0;
        end
      end
      LOCKED: begin
        phase_nx = phase_q + 5'd1;
        if (on_phase) begin
          fault_nx = 3'd0;
        end else if (bus.sync_in || miss) begin
          fault_nx = fault_q + 3'd1;
          err_nx   = 1'b1;
          if (fault_q + 3'd1 == LOSS_MAX) begin
            state_nx = SEARCH;
            phase_nx = 5'd0;
          end
        end
      end
      default: begin
        state_nx = SEARCH;
        phase_nx = 5'd0;
      end
    endcase
  end

  // State register with synchronous reset back to hunting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      phase_q   <= 5'd0;
      confirm_q <= 3'd0;
      fault_q   <= 3'd0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      phase_q   <= phase_nx;
      confirm_q <= confirm_nx;
      fault_q   <= fault_nx;
      err_q     <= err_nx;
    end
  end

  assign bus.phase    = phase_q;
  assign bus.locked   = is_locked;
  assign bus.sync_err = err_q;
  assign bus.en_2     = is_locked && phase_q[0];
  assign bus.en_16    = is_locked && (phase_q[3:0] == 4'd15);
  assign bus.en_32    = is_locked && (phase_q == 5'd31);

endmodule
